// File: rtl/mac_mdc_stream_join.sv
// Join stage for the mac_mdc operand streams: buffers a/b/c independently and
// releases them as index-aligned tuples, with a per-job element budget.
module mac_mdc_stream_join #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [CNT_WIDTH-1:0]    len_i,

    input  logic                    a_i_valid,
    output logic                    a_i_ready,
    input  logic [DATA_WIDTH-1:0]   a_i_data,
    input  logic [DATA_WIDTH/8-1:0] a_i_strb,
    input  logic                    b_i_valid,
    output logic                    b_i_ready,
    input  logic [DATA_WIDTH-1:0]   b_i_data,
    input  logic [DATA_WIDTH/8-1:0] b_i_strb,
    input  logic                    c_i_valid,
    output logic                    c_i_ready,
    input  logic [DATA_WIDTH-1:0]   c_i_data,
    input  logic [DATA_WIDTH/8-1:0] c_i_strb,

    output logic                    a_o_valid,
    input  logic                    a_o_ready,
    output logic [DATA_WIDTH-1:0]   a_o_data,
    output logic [DATA_WIDTH/8-1:0] a_o_strb,
    output logic                    b_o_valid,
    input  logic                    b_o_ready,
    output logic [DATA_WIDTH-1:0]   b_o_data,
    output logic [DATA_WIDTH/8-1:0] b_o_strb,
    output logic                    c_o_valid,
    input  logic                    c_o_ready,
    output logic [DATA_WIDTH-1:0]   c_o_data,
    output logic [DATA_WIDTH/8-1:0] c_o_strb,

    output logic                    busy_o,
    output logic                    done_o,
    output logic [CNT_WIDTH-1:0]    cnt_o
);

    // state | meaning
    // IDLE  | waiting for start_i; len_i sampled here
    // RUN   | accepting beats and releasing tuples
    // DONE  | one-cycle completion pulse on done_o

    localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned ENTRY_WIDTH = DATA_WIDTH + STRB_WIDTH;
    localparam int unsigned AW          = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_WIDTH   = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [2:0]             in_valid, in_ready, in_push;
    logic [2:0]             out_valid, out_ready, out_hs;
    logic [2:0]             taken_q, fifo_full, fifo_empty;
    logic [ENTRY_WIDTH-1:0] in_entry [3];
    logic [ENTRY_WIDTH-1:0] head [3];
    logic [ENTRY_WIDTH-1:0] mem_q [3][FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]   wptr_q [3];
    logic [PTR_WIDTH-1:0]   rptr_q [3];
    logic [CNT_WIDTH-1:0]   in_cnt_q [3];
    logic [CNT_WIDTH-1:0]   cnt_q, len_q;
    logic                   run, tuple_avail, tuple_done, last_tuple, start_ok;

    assign in_valid    = {c_i_valid, b_i_valid, a_i_valid};
    assign out_ready   = {c_o_ready, b_o_ready, a_o_ready};
    assign in_entry[0] = {a_i_data, a_i_strb};
    assign in_entry[1] = {b_i_data, b_i_strb};
    assign in_entry[2] = {c_i_data, c_i_strb};

    assign {c_i_ready, b_i_ready, a_i_ready} = in_ready;
    assign {c_o_valid, b_o_valid, a_o_valid} = out_valid;

    assign a_o_data = head[0][ENTRY_WIDTH-1:STRB_WIDTH];
    assign a_o_strb = head[0][STRB_WIDTH-1:0];
    assign b_o_data = head[1][ENTRY_WIDTH-1:STRB_WIDTH];
    assign b_o_strb = head[1][STRB_WIDTH-1:0];
    assign c_o_data = head[2][ENTRY_WIDTH-1:STRB_WIDTH];
    assign c_o_strb = head[2][STRB_WIDTH-1:0];

    assign run      = (state_q == RUN);
    assign start_ok = (state_q == IDLE) && start_i;
    assign cnt_o    = cnt_q;

    // Ready looks only at the registered full flag, so a pop never feeds back
    // into ready within the same cycle.
    always_comb begin
        fifo_empty = '0;
        fifo_full  = '0;
        in_ready   = '0;
        in_push    = '0;
        for (int l = 0; l < 3; l++) begin
            fifo_empty[l] = (wptr_q[l] == rptr_q[l]);
            fifo_full[l]  = (wptr_q[l][AW] != rptr_q[l][AW]) &&
                            (wptr_q[l][AW-1:0] == rptr_q[l][AW-1:0]);
            head[l]       = mem_q[l][rptr_q[l][AW-1:0]];
            in_ready[l]   = run && !fifo_full[l] && (in_cnt_q[l] < len_q);
            in_push[l]    = in_valid[l] && in_ready[l];
        end
    end

    assign tuple_avail = run && !(|fifo_empty);

    always_comb begin
        out_valid = '0;
        out_hs    = '0;
        if (tuple_avail) begin
            out_valid = ~taken_q;
        end
        out_hs = out_valid & out_ready;
    end

    assign tuple_done = tuple_avail && (&(taken_q | out_hs));
    assign last_tuple = tuple_done && (cnt_q == len_q - CNT_WIDTH'(1));

    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (len_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (last_tuple) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clear_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_q   <= '0;
            cnt_q   <= '0;
            taken_q <= '0;
            for (int l = 0; l < 3; l++) begin
                in_cnt_q[l] <= '0;
                wptr_q[l]   <= '0;
                rptr_q[l]   <= '0;
            end
        end else if (clear_i) begin
            len_q   <= '0;
            cnt_q   <= '0;
            taken_q <= '0;
            for (int l = 0; l < 3; l++) begin
                in_cnt_q[l] <= '0;
                wptr_q[l]   <= '0;
                rptr_q[l]   <= '0;
            end
        end else if (start_ok) begin
            len_q   <= len_i;
            cnt_q   <= '0;
            taken_q <= '0;
            for (int l = 0; l < 3; l++) begin
                in_cnt_q[l] <= '0;
            end
        end else begin
            for (int l = 0; l < 3; l++) begin
                if (in_push[l]) begin
                    in_cnt_q[l] <= in_cnt_q[l] + CNT_WIDTH'(1);
                    wptr_q[l]   <= wptr_q[l] + PTR_WIDTH'(1);
                end
                if (tuple_done) begin
                    rptr_q[l]  <= rptr_q[l] + PTR_WIDTH'(1);
                    taken_q[l] <= 1'b0;
                end else if (out_hs[l]) begin
                    taken_q[l] <= 1'b1;
                end
            end
            if (tuple_done) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk_i) begin
        for (int l = 0; l < 3; l++) begin
            if (in_push[l]) begin
                mem_q[l][wptr_q[l][AW-1:0]] <= in_entry[l];
            end
        end
    end

endmodule

// File: doc/mac_mdc_stream_join.md
# mac_mdc_stream_join

Input-side join stage placed between the three HWPE source streamers and the mac_mdc kernel adapter sinks. It buffers the a, b and c operand streams independently and releases them to the kernel as aligned tuples, one tuple per element index. It enforces a per-job element budget of `len_i` on every input. It reports busy and done status to the engine FSM.

## Interface
Parameters:
- DATA_WIDTH, 32, data width of every stream (strb width DATA_WIDTH/8)
- FIFO_DEPTH, 2, entries per lane buffer (power of two, ≥2)
- CNT_WIDTH, 16, width of the element counters and `len_i`

Ports (clock and reset first):
- clk_i  in  1  single clock; all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- clear_i  in  1  synchronous flush of FIFOs, counters and FSM
- start_i  in  1  one-cycle job start; sampled only in IDLE
- len_i  in  CNT_WIDTH  tuples per job; sampled with start_i
- a_i, b_i, c_i  sink  hwpe_stream_intf_stream  operand streams from the streamers
- a_o, b_o, c_o  source  hwpe_stream_intf_stream  aligned operand streams to the kernel adapter
- busy_o  out  1  high while the FSM is in RUN
- done_o  out  1  one-cycle pulse at job completion
- cnt_o  out  CNT_WIDTH  tuples fully delivered in the current job

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN: start_i=1 with len_i≠0. Latch len_i; zero all counters.
  - IDLE→DONE: start_i=1 with len_i=0.
  - RUN→DONE: on the cycle the tuple with index len−1 completes.
  - DONE→IDLE: unconditional; done_o=1 only in DONE.
  - start_i outside IDLE is ignored.
- Per-lane input (x∈{a,b,c}):
  - Buffer: FIFO of {data,strb}.
  - Input counter in_cnt_x.
  - x_i.ready = RUN & FIFO_x not full & in_cnt_x<len.
  - in_cnt_x increments on each x_i handshake.
  - Effect: a lane never accepts more than len beats per job.
- Tuple release:
  - tuple_avail = RUN & all three FIFOs non-empty.
  - Each lane carries a taken_x flag.
  - x_o.valid = tuple_avail & ~taken_x. Valid never depends on x_o.ready.
  - x_o.data/strb = head of FIFO_x.
  - A handshake on x_o sets taken_x.
  - Tuple completes when, for every lane, taken_x or a handshake on x_o this cycle. On completion: pop all three FIFOs, clear all taken flags, increment cnt_o.
  - Lanes may be consumed in any order or in different cycles. The next tuple is presented only after all three lanes are consumed.
- Arithmetic: counters are unsigned CNT_WIDTH. len ≤ 2^CNT_WIDTH−1. No wrap occurs within a job.
- Simultaneous push and pop on a full FIFO is allowed. Ready uses the pre-pop full flag (no combinational ready→ready path).
- clear_i (sync):
  - Empties FIFOs; zeroes counters and taken flags; FSM→IDLE.
  - No done_o pulse. Has priority over start_i.
- rst_i (async) during operation: identical end state to clear_i, applied immediately.

## Timing
- Reset values:
  - all x_o.valid=0, x_i.ready=0
  - busy_o=0, done_o=0, cnt_o=0
  - FSM=IDLE, FIFOs empty, taken flags 0
- start_i at cycle t → busy_o=1 and readys eligible from t+1.
- Registered FIFOs with no fall-through. A beat accepted at cycle t is visible on x_o at t+1 at the earliest.
- Throughput is one tuple/cycle when all x_o.ready=1 and inputs stream continuously.
- Last tuple completes at cycle t → DONE at t+1 (done_o=1, busy_o=0) → IDLE at t+2. A new start_i is accepted from t+2.
- cnt_o updates the cycle after the completing handshake. cnt_o holds its final value through DONE and IDLE until the next start_i.
- len_i=0: start at t → done_o=1 at t+1. No ready is ever raised.

## Test plan
- Basic job: len=4, all inputs stream from t+1, all x_o.ready=1 → four tuples on consecutive cycles, data order preserved, cnt_o=4, single done_o pulse, busy_o low after.
- Skewed lanes: b_o.ready stalled 3 cycles while a_o and c_o ready → a and c handshake once and drop valid; b delivered later. Tuple 0 completes only then, and tuple 1 appears the following cycle.
- Starved lane: c_i delayed 5 cycles, len=2 → a_i and b_i stall once their FIFOs are full (2 beats); no x_o.valid until c arrives; final cnt_o=2.
- Budget limit: len=3, each input offers 6 beats → exactly 3 accepted per lane, x_i.ready=0 afterwards, done_o once, remaining beats untouched.
- Boundary starts: len=0 → done_o at t+1, no handshakes. start_i pulsed during RUN → ignored, len unchanged.
- Abort: clear_i asserted mid-job (2 tuples in flight) → next cycle FIFOs empty, all valid/ready 0, cnt_o=0, no done_o. Repeat the same scenario with rst_i asserted asynchronously mid-cycle.
